irb_port_arb: RTL and testbench
===============================

# irb_port_arb

Two-requester burst arbiter for the single-port image result buffer (IRB, 64 x 8 synchronous SRAM). It sits between the LCD controller's write-back engine and the display scan reader, grants whole bursts round-robin, and generates the wrapping IRB addresses. Each granted burst owns the port for its full length; one access is issued per cycle.

## Interface
- ADDR_W, 6, IRB address width (64 pixels)
- DATA_W, 8, pixel width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wr_req  in  1  write-back burst request; held high until wr_gnt
- wr_start  in  ADDR_W  first write address, sampled at grant
- wr_len  in  ADDR_W  burst length; 0 means 64
- wr_data  in  DATA_W  pixel for the current wr_idx, same cycle
- wr_gnt  out  1  high for every cycle of a write burst
- wr_idx  out  ADDR_W  beat index within the write burst (0..len-1)
- wr_done  out  1  one-cycle pulse after the last write beat
- rd_req / rd_start / rd_len  in  1 / ADDR_W / ADDR_W  read-burst equivalents
- rd_gnt  out  1  high for every address cycle of a read burst
- rd_valid  out  1  rd_data valid, one cycle after each read address
- rd_data  out  DATA_W  registered IRB_Q
- rd_idx  out  ADDR_W  beat index of rd_data
- rd_done  out  1  one-cycle pulse, coincident with the last rd_valid
- IRB_CEN  out  1  active-low chip enable
- IRB_RW  out  1  1 = read, 0 = write
- IRB_A  out  ADDR_W  SRAM address
- IRB_D  out  DATA_W  SRAM write data
- IRB_Q  in  DATA_W  SRAM read data, valid one cycle after its address

## Operation
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE: when only one request is high, that requester is granted. When both are high, the requester not granted last wins. The last-grant flag resets to "read", so write wins the first tie.
- Grant: at the edge that leaves IDLE, latch start, len (0→64) and clear beat counter cnt.
- In a burst: IRB_CEN=0; IRB_A = (start + cnt) mod 64, wrapping 63→0; cnt increments each cycle.
- On the last beat (cnt = len-1), the FSM returns to IDLE.
- WR_BURST: IRB_RW=0 and IRB_D=wr_data (combinational pass-through); wr_idx=cnt.
- RD_BURST: IRB_RW=1. A 1-stage pipeline captures IRB_Q into rd_data, with rd_valid and rd_idx delayed by one cycle.
- Requests are sampled only in IDLE. Dropping a request mid-burst is ignored, and the burst always completes.
- Outside bursts: IRB_CEN=1, IRB_RW=1, IRB_A=0, IRB_D=0.
- All outputs except IRB_D are decoded from registers only.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE;
  - IRB_CEN=1, IRB_RW=1, IRB_A=0, IRB_D=0;
  - all gnt/done/valid = 0; rd_data=0, rd_idx=0, wr_idx=0;
  - last-grant = read.
- Reset mid-burst abandons the burst immediately. No further IRB write occurs, and no done pulse is produced.
- Request sampled high in IDLE at edge N → gnt high and first access in cycle N+1.
- A burst of L beats occupies cycles N+1..N+L, with IDLE in cycle N+L+1.
- Minimum one IDLE cycle between any two bursts.
- Write: beat k is written at the edge ending cycle N+1+k. wr_done is high in cycle N+L+1.
- Read: rd_valid is high in cycles N+2..N+L+1. rd_done is high in cycle N+L+1.
- Back-to-back requests from the same requester with the other idle are re-granted after the single IDLE cycle.
- A read grant may start while the previous read's final rd_valid is still draining. The pipeline carries it and there is no conflict.

## Structure
- Shared package lcd_pkg holds:
  - IMG_PIXELS=64 and the ADDR_W/DATA_W defaults;
  - arb_state_t enum {IDLE, WR_BURST, RD_BURST};
  - IRB_RD=1'b1 and IRB_WR=1'b0 constants.
- One natural sub-module, rr_arb2: combinational 2-way round-robin pick plus the last-grant register.
- Address counter, FSM and read pipeline live in irb_port_arb.

## Test plan
- Write alone: wr_start=0, wr_len=0 with wr_data=wr_idx.
  - wr_gnt for 64 cycles; IRB mem[k]=k for all k; wr_done once in cycle 65.
- Wrap: wr_start=62, wr_len=4, data 0xA0+idx → mem[62]=A0, mem[63]=A1, mem[0]=A2, mem[1]=A3; nothing else changes.
- Read after the write above: rd_start=62, rd_len=4.
  - rd_valid for 4 cycles, starting 2 cycles after request, with rd_data A0,A1,A2,A3 and rd_idx 0..3.
  - rd_done on the A3 cycle.
- Tie after reset: both requests high in the same cycle.
  - Write burst granted first; read granted exactly one IDLE cycle after wr_done.
  - On the next tie, write is granted after the read.
- Reset mid-write: assert reset during beat 3 of an 8-beat write.
  - IRB_CEN=1 the same cycle; only beats 0–2 are written; no wr_done.
  - After release, the FSM is IDLE and a new wr_req is granted normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD/IRB definitions: image size, bus widths, arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lcd_pkg;

    localparam int IMG_PIXELS = 64;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } arb_state_t;

    // IRB_RW encoding of the image result buffer
    localparam logic IRB_RD = 1'b1;
    localparam logic IRB_WR = 1'b0;

endpackage

// File: rtl/irb_port_arb_rr_arb2.sv
// Two-way round-robin pick between write-back and scan-read requesters.
// Latency: combinational pick; last-grant register updates at the granting edge.
// Backpressure: only picks while arb_en is high; requesters hold req until granted.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic wr_req,
    input  logic rd_req,
    output logic pick_wr,
    output logic pick_rd
);

    // 1 = the read side won the most recent arbitration
    logic last_rd;

    // Single requester wins outright; on a tie the side not granted last wins
    always_comb begin
        pick_wr = 1'b0;
        pick_rd = 1'b0;
        if (arb_en) begin
            if (wr_req && rd_req) begin
                pick_wr = last_rd;
                pick_rd = !last_rd;
            end else begin
                pick_wr = wr_req;
                pick_rd = rd_req;
            end
        end
    end

    // Remember who won; starts as "read" so write takes the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_rd <= 1'b1;
        end else if (pick_wr) begin
            last_rd <= 1'b0;
        end else if (pick_rd) begin
            last_rd <= 1'b1;
        end
    end

endmodule

// File: rtl/irb_port_arb.sv
// Burst arbiter for the single-port IRB: grants whole write/read bursts round-robin, wraps addresses.
// Latency: grant 1 cycle after request; read data 1 cycle after its address; done 1 cycle after last beat.
// Backpressure: requests held until gnt; a granted burst always runs to completion, one beat per cycle.
module irb_port_arb
    import lcd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_start,
    input  logic [ADDR_W-1:0] wr_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] wr_idx,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_start,
    input  logic [ADDR_W-1:0] rd_len,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_idx,
    output logic              rd_done,
    output logic              IRB_CEN,
    output logic              IRB_RW,
    output logic [ADDR_W-1:0] IRB_A,
    output logic [DATA_W-1:0] IRB_D,
    input  logic [DATA_W-1:0] IRB_Q
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    arb_state_t        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] start;
    // len-1 kept directly: a length of 0 naturally becomes all-ones, i.e. a full-buffer burst
    logic [ADDR_W-1:0] last_cnt;
    logic              pick_wr;
    logic              pick_rd;
    logic              in_wr;
    logic              in_rd;
    logic              last_beat;

    assign in_wr     = (state == WR_BURST);
    assign in_rd     = (state == RD_BURST);
    assign last_beat = (cnt == last_cnt);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (state == IDLE),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .pick_wr (pick_wr),
        .pick_rd (pick_rd)
    );

    // Burst FSM: latch the granted burst, step the beat counter, return to IDLE after the last beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            start    <= '0;
            last_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_wr) begin
                        state    <= WR_BURST;
                        start    <= wr_start;
                        last_cnt <= wr_len - ONE;
                    end else if (pick_rd) begin
                        state    <= RD_BURST;
                        start    <= rd_start;
                        last_cnt <= rd_len - ONE;
                    end
                end
                WR_BURST, RD_BURST: begin
                    cnt <= cnt + ONE;
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion pulses and the one-stage read-return pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_idx   <= '0;
        end else begin
            wr_done  <= in_wr && last_beat;
            rd_done  <= in_rd && last_beat;
            rd_valid <= in_rd;
            if (in_rd) begin
                rd_data <= IRB_Q;
                rd_idx  <= cnt;
            end
        end
    end

    // Port decode from state/counter registers; the address wraps modulo the buffer size
    assign wr_gnt  = in_wr;
    assign rd_gnt  = in_rd;
    assign wr_idx  = in_wr ? cnt : '0;
    assign IRB_CEN = !(in_wr || in_rd);
    assign IRB_RW  = in_wr ? IRB_WR : IRB_RD;
    assign IRB_A   = (in_wr || in_rd) ? (start + cnt) : '0;
    // Write data is a same-cycle pass-through from the write-back engine
    assign IRB_D   = in_wr ? wr_data : '0;

endmodule

// File: tb/tb_irb_port_arb.sv
module tb_irb_port_arb;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_req = 1'b0;
    logic [5:0] wr_start = '0;
    logic [5:0] wr_len = '0;
    logic [7:0] wr_data;
    logic       wr_gnt;
    logic [5:0] wr_idx;
    logic       wr_done;
    logic       rd_req = 1'b0;
    logic [5:0] rd_start = '0;
    logic [5:0] rd_len = '0;
    logic       rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [5:0] rd_idx;
    logic       rd_done;
    logic       IRB_CEN;
    logic       IRB_RW;
    logic [5:0] IRB_A;
    logic [7:0] IRB_D;
    logic [7:0] IRB_Q;

    logic [7:0] wr_base = 8'h00;
    logic [7:0] mem     [64];
    logic [7:0] exp_mem [64];

    int checks = 0;
    int errors = 0;

    irb_port_arb dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_start(wr_start), .wr_len(wr_len), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .wr_idx(wr_idx), .wr_done(wr_done),
        .rd_req(rd_req), .rd_start(rd_start), .rd_len(rd_len),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx), .rd_done(rd_done),
        .IRB_CEN(IRB_CEN), .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D), .IRB_Q(IRB_Q)
    );

    always #5 clk = ~clk;

    // Write-back engine supplies pixel = base + beat index
    assign wr_data = wr_base + {2'b00, wr_idx};

    // SRAM model: writes at the clock edge; read data presented for capture at the edge closing the address cycle
    assign IRB_Q = mem[IRB_A];
    always @(posedge clk) begin
        if (!IRB_CEN && (IRB_RW == 1'b0)) mem[IRB_A] <= IRB_D;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < 64; i++) chk($sformatf("%s mem[%0d]", tag, i), {24'd0, mem[i]}, {24'd0, exp_mem[i]});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset state ----------------
        wr_base = 8'h33;
        tick(); tick();
        chk("rst IRB_CEN", IRB_CEN, 1);
        chk("rst IRB_RW", IRB_RW, 1);
        chk("rst IRB_A", IRB_A, 0);
        chk("rst IRB_D", IRB_D, 0);
        chk("rst wr_gnt", wr_gnt, 0);
        chk("rst rd_gnt", rd_gnt, 0);
        chk("rst wr_done", wr_done, 0);
        chk("rst rd_done", rd_done, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst rd_idx", rd_idx, 0);
        chk("rst wr_idx", wr_idx, 0);
        reset = 1'b1;
        tick();

        // ---------------- write alone: full 64-beat burst, data = idx ----------------
        wr_base = 8'h00; wr_start = 6'd0; wr_len = 6'd0; wr_req = 1'b1;
        tick();
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("w64 gnt k%0d", k), wr_gnt, 1);
            chk($sformatf("w64 idx k%0d", k), wr_idx, k);
            chk($sformatf("w64 A k%0d", k), IRB_A, k);
            chk($sformatf("w64 done k%0d", k), wr_done, 0);
            if (k == 0) begin
                chk("w64 CEN", IRB_CEN, 0);
                chk("w64 RW", IRB_RW, 0);
                wr_req = 1'b0;
            end
            tick();
        end
        chk("w64 gnt end", wr_gnt, 0);
        chk("w64 done", wr_done, 1);
        chk("w64 CEN end", IRB_CEN, 1);
        tick();
        chk("w64 done once", wr_done, 0);
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i);
        chk_mem("w64");

        // ---------------- wrapping write: 62,63,0,1 ----------------
        wr_base = 8'hA0; wr_start = 6'd62; wr_len = 6'd4; wr_req = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap gnt k%0d", k), wr_gnt, 1);
            chk($sformatf("wrap A k%0d", k), IRB_A, (62 + k) % 64);
            chk($sformatf("wrap D k%0d", k), IRB_D, 8'hA0 + k);
            if (k == 0) wr_req = 1'b0;
            tick();
        end
        chk("wrap done", wr_done, 1);
        chk("wrap gnt end", wr_gnt, 0);
        tick();
        exp_mem[62] = 8'hA0; exp_mem[63] = 8'hA1; exp_mem[0] = 8'hA2; exp_mem[1] = 8'hA3;
        chk_mem("wrap");

        // ---------------- wrapping read back ----------------
        rd_start = 6'd62; rd_len = 6'd4; rd_req = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                chk($sformatf("rd gnt k%0d", k), rd_gnt, 1);
                chk($sformatf("rd A k%0d", k), IRB_A, (62 + k) % 64);
                chk($sformatf("rd RW k%0d", k), IRB_RW, 1);
                chk($sformatf("rd CEN k%0d", k), IRB_CEN, 0);
            end else begin
                chk("rd gnt end", rd_gnt, 0);
                chk("rd CEN end", IRB_CEN, 1);
            end
            if (k >= 1) begin
                chk($sformatf("rd valid k%0d", k), rd_valid, 1);
                chk($sformatf("rd data k%0d", k), rd_data, 8'hA0 + k - 1);
                chk($sformatf("rd idx k%0d", k), rd_idx, k - 1);
                chk($sformatf("rd done k%0d", k), rd_done, (k == 4) ? 1 : 0);
            end else begin
                chk("rd valid first", rd_valid, 0);
            end
            if (k == 0) rd_req = 1'b0;
            tick();
        end
        chk("rd valid after", rd_valid, 0);
        chk("rd done after", rd_done, 0);

        // ---------------- ties after reset ----------------
        reset = 1'b0; tick(); reset = 1'b1; tick();
        wr_base = 8'h10; wr_start = 6'd5; wr_len = 6'd2; rd_start = 6'd5; rd_len = 6'd2;
        wr_req = 1'b1; rd_req = 1'b1;
        tick();                                   // N+1
        chk("tie1 wr_gnt", wr_gnt, 1);
        chk("tie1 rd_gnt", rd_gnt, 0);
        wr_req = 1'b0;
        tick();                                   // N+2
        chk("tie1 wr_gnt b1", wr_gnt, 1);
        tick();                                   // N+3 idle
        chk("tie1 wr_done", wr_done, 1);
        chk("tie1 idle gap", rd_gnt, 0);
        tick();                                   // N+4
        chk("tie1 rd_gnt", rd_gnt, 1);
        chk("tie1 rd A", IRB_A, 5);
        rd_req = 1'b0;
        tick();                                   // N+5
        chk("tie1 rd_gnt b1", rd_gnt, 1);
        tick();                                   // N+6
        chk("tie1 rd_done", rd_done, 1);
        chk("tie1 rd_data", rd_data, 8'h11);
        chk("tie1 rd_gnt end", rd_gnt, 0);
        wr_req = 1'b1; rd_req = 1'b1;
        tick();                                   // N+7
        chk("tie2 wr_gnt", wr_gnt, 1);
        chk("tie2 rd_gnt", rd_gnt, 0);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); tick();                           // N+9 idle
        chk("tie2 wr_done", wr_done, 1);
        wr_req = 1'b1; rd_req = 1'b1;
        tick();                                   // N+10
        chk("tie3 rd_gnt", rd_gnt, 1);
        chk("tie3 wr_gnt", wr_gnt, 0);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); tick();                           // N+12
        chk("tie3 rd_done", rd_done, 1);
        tick();
        exp_mem[5] = 8'h10; exp_mem[6] = 8'h11;

        // ---------------- reset during beat 3 of an 8-beat write ----------------
        wr_base = 8'h50; wr_start = 6'd10; wr_len = 6'd8; wr_req = 1'b1;
        tick();                                   // beat 0
        wr_req = 1'b0;
        tick(); tick(); tick();                   // beat 3
        chk("rstmid gnt b3", wr_gnt, 1);
        chk("rstmid idx b3", wr_idx, 3);
        reset = 1'b0;
        #1;
        chk("rstmid CEN", IRB_CEN, 1);
        chk("rstmid gnt", wr_gnt, 0);
        chk("rstmid A", IRB_A, 0);
        tick();
        chk("rstmid done hold", wr_done, 0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstmid no done %0d", k), wr_done, 0);
            chk($sformatf("rstmid no gnt %0d", k), wr_gnt, 0);
        end
        exp_mem[10] = 8'h50; exp_mem[11] = 8'h51; exp_mem[12] = 8'h52;
        chk_mem("rstmid");

        wr_base = 8'h77; wr_start = 6'd20; wr_len = 6'd1; wr_req = 1'b1;
        tick();
        chk("post gnt", wr_gnt, 1);
        chk("post A", IRB_A, 20);
        wr_req = 1'b0;
        tick();
        chk("post done", wr_done, 1);
        tick();
        exp_mem[20] = 8'h77;
        chk("post mem20", mem[20], exp_mem[20]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
